// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants for the BRAM port arbiter: requester IDs, default widths
// and the full-word write-enable pattern.
package bram_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef enum logic {
    REQ_CFG = 1'b0,
    REQ_ENG = 1'b1
  } req_id_t;

  localparam logic [3:0] WE_FULL = 4'hF;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Bundle of the two requester ports, the BRAM port and the conflict counter.
// master: requesters + BRAM macro side; slave: the arbiter.
interface bram_port_arbiter_if
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned pDATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                   r0_valid;
  logic                   r0_we;
  logic [pADDR_WIDTH-1:0] r0_addr;
  logic [pDATA_WIDTH-1:0] r0_wdata;
  logic                   r0_gnt;
  logic                   r0_rvalid;
  logic [pDATA_WIDTH-1:0] r0_rdata;

  logic                   r1_valid;
  logic                   r1_we;
  logic [pADDR_WIDTH-1:0] r1_addr;
  logic [pDATA_WIDTH-1:0] r1_wdata;
  logic                   r1_gnt;
  logic                   r1_rvalid;
  logic [pDATA_WIDTH-1:0] r1_rdata;

  logic [3:0]             bram_WE;
  logic                   bram_EN;
  logic [pDATA_WIDTH-1:0] bram_Di;
  logic [pADDR_WIDTH-1:0] bram_A;
  logic [pDATA_WIDTH-1:0] bram_Do;

  logic [15:0]            conflict_cnt;

  modport master (
    output r0_valid, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_valid, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  bram_WE, bram_EN, bram_Di, bram_A,
    output bram_Do,
    input  conflict_cnt
  );

  modport slave (
    input  r0_valid, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_valid, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output bram_WE, bram_EN, bram_Di, bram_A,
    input  bram_Do,
    output conflict_cnt
  );

endinterface

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for a single BRAM port. The engine side (r1) has
// priority; the configuration side (r0) is forced through after MAX_WAIT
// denied cycles. Read data returns one cycle after the grant to the owner.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned pDATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_WAIT    = 4
) (
  input logic                axis_clk,
  input logic                axis_rst,
  bram_port_arbiter_if.slave bus
);

  localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0]      wait0_q;
  logic [15:0]            conflict_cnt_q;
  logic                   rd_pend_q;
  req_id_t                rd_owner_q;

  logic                   both_valid;
  logic                   gnt0;
  logic                   gnt1;
  req_id_t                winner;
  logic                   win_we;
  logic [pADDR_WIDTH-1:0] win_addr;
  logic [pDATA_WIDTH-1:0] win_wdata;
  logic                   rv0;
  logic                   rv1;

  // Grant decision: r1 by default, r0 once it has waited MAX_WAIT cycles.
  always_comb begin
    both_valid = bus.r0_valid && bus.r1_valid;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    if (!axis_rst) begin
      if (both_valid) begin
        if (wait0_q == WAIT_SAT) gnt0 = 1'b1;
        else                     gnt1 = 1'b1;
      end else if (bus.r0_valid) begin
        gnt0 = 1'b1;
      end else if (bus.r1_valid) begin
        gnt1 = 1'b1;
      end
    end
    winner    = gnt0 ? REQ_CFG : REQ_ENG;
    win_we    = gnt0 ? bus.r0_we    : bus.r1_we;
    win_addr  = gnt0 ? bus.r0_addr  : bus.r1_addr;
    win_wdata = gnt0 ? bus.r0_wdata : bus.r1_wdata;
  end

  // BRAM port drive: everything zero unless a requester holds the grant.
  always_comb begin
    bus.bram_EN = 1'b0;
    bus.bram_WE = '0;
    bus.bram_A  = '0;
    bus.bram_Di = '0;
    if (gnt0 || gnt1) begin
      bus.bram_EN = 1'b1;
      bus.bram_A  = win_addr;
      if (win_we) begin
        bus.bram_WE = WE_FULL;
        bus.bram_Di = win_wdata;
      end
    end
  end

  // State: r0 starvation counter, conflict counter, read-return tag.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wait0_q        <= '0;
      conflict_cnt_q <= '0;
      rd_pend_q      <= 1'b0;
      rd_owner_q     <= REQ_CFG;
    end else begin
      if (!bus.r0_valid || gnt0) wait0_q <= '0;
      else if (wait0_q != WAIT_SAT) wait0_q <= wait0_q + 1'b1;

      if (both_valid && (conflict_cnt_q != '1))
        conflict_cnt_q <= conflict_cnt_q + 16'd1;

      rd_pend_q  <= (gnt0 || gnt1) && !win_we;
      rd_owner_q <= winner;
    end
  end

  // Outputs; gating with reset kills a read return already in flight.
  always_comb begin
    rv0               = rd_pend_q && (rd_owner_q == REQ_CFG) && !axis_rst;
    rv1               = rd_pend_q && (rd_owner_q == REQ_ENG) && !axis_rst;
    bus.r0_gnt        = gnt0;
    bus.r1_gnt        = gnt1;
    bus.r0_rvalid     = rv0;
    bus.r1_rvalid     = rv1;
    bus.r0_rdata      = rv0 ? bus.bram_Do : '0;
    bus.r1_rdata      = rv1 ? bus.bram_Do : '0;
    bus.conflict_cnt  = axis_rst ? '0 : conflict_cnt_q;
  end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The block SHALL have parameter pADDR_WIDTH, default 12, meaning BRAM word-address/byte-address width.
REQ-002 The block SHALL have parameter pDATA_WIDTH, default 32, meaning BRAM data width.
REQ-003 The block SHALL have parameter MAX_WAIT, default 4, meaning cycles requester 0 may be denied before it is forced to win.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset: axis_clk, axis_rst.
REQ-005 The block SHALL have these ports:
- axis_clk  in  1  clock, all logic on rising edge.
- axis_rst  in  1  synchronous active-high reset.
- r0_valid  in  1  configuration-side (AXI-Lite) request.
- r0_we  in  1  write (1) / read (0).
- r0_addr  in  pADDR_WIDTH  byte address.
- r0_wdata  in  pDATA_WIDTH  write data.
- r0_gnt  out  1  request accepted this cycle.
- r0_rvalid  out  1  read data valid.
- r0_rdata  out  pDATA_WIDTH  read data.
- r1_valid, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same directions and widths, engine-side requester.
- bram_WE  out  4  byte write enables.
- bram_EN  out  1  port enable.
- bram_Di  out  pDATA_WIDTH  write data.
- bram_A  out  pADDR_WIDTH  address.
- bram_Do  in  pDATA_WIDTH  read data, 1-cycle latency.
- conflict_cnt  out  16  saturating count of cycles with both requests valid.

Function
REQ-006 The block SHALL grant at most one requester per cycle; rN_gnt is combinational from the current inputs and registered state.
REQ-007 The block SHALL grant requester 1 when only r1_valid is high, and requester 0 when only r0_valid is high.
REQ-008 When both are valid, the block SHALL grant requester 1 unless wait0 == MAX_WAIT, in which case it SHALL grant requester 0.
REQ-009 wait0 SHALL increment, saturating at MAX_WAIT, each cycle r0_valid=1 and r0_gnt=0.
REQ-010 wait0 SHALL clear to 0 on r0_gnt or on any cycle with r0_valid=0.
REQ-011 In a granted cycle, bram_EN SHALL be 1 and bram_A SHALL equal the winner's addr.
REQ-012 In a granted write cycle, bram_WE SHALL be 4'hF and bram_Di SHALL equal the winner's wdata.
REQ-013 In a granted read cycle, bram_WE SHALL be 0.
REQ-014 In a cycle with no grant, bram_EN, bram_WE, bram_A and bram_Di SHALL all be 0.
REQ-015 A requester SHALL hold valid/we/addr/wdata stable until it sees gnt; the block SHALL NOT latch un-granted requests.
REQ-016 For a granted read, the block SHALL register a one-bit owner tag and read flag.
REQ-017 On the cycle after a granted read, the owner's rN_rvalid SHALL be 1 for exactly one cycle with rN_rdata = bram_Do; the other requester's rvalid SHALL be 0.
REQ-018 rN_rdata SHALL be 0 whenever rN_rvalid is 0.
REQ-019 Back-to-back reads SHALL sustain one grant per cycle, with rvalid pipelined one cycle behind each grant.
REQ-020 A write granted in the cycle after a read SHALL NOT disturb that read's rvalid/rdata.
REQ-021 conflict_cnt SHALL increment by 1 each cycle both valids are high, and SHALL hold at 16'hFFFF.

Reset
REQ-022 While axis_rst=1, all outputs SHALL be 0 and no grant SHALL be issued regardless of valids.
REQ-023 Reset SHALL clear wait0, the read-owner tag, the read flag and conflict_cnt to 0.
REQ-024 If reset is asserted while a read is in flight, the block SHALL suppress the rvalid that read would have produced.

Structure
REQ-025 A shared package SHALL hold: the requester-ID constants (REQ_CFG=0, REQ_ENG=1), the default address/data widths, and the 4'hF full-word write-enable constant.
REQ-026 The design SHALL be one flat module; no sub-module is required.

Verification
REQ-027 r0 write addr 0x040 data 0x0000_0005, r1 idle -> same-cycle r0_gnt=1, bram_EN=1, bram_WE=4'hF, bram_A=0x040, bram_Di=5.
REQ-028 r1 read addr 0x044 with bram_Do=0x1234 -> r1_gnt=1 in cycle T; r1_rvalid=1 and r1_rdata=0x1234 in T+1; r0_rvalid=0.
REQ-029 Both valid continuously, MAX_WAIT=4 -> r1 granted 4 cycles, r0 granted on the 5th, then r1 again; conflict_cnt=5 after 5 cycles.
REQ-030 Alternating r0 read (0x048) and r1 read (0x04C) every cycle -> each rvalid goes to the correct owner, one cycle late, with no gap.
REQ-031 r1 read granted, then axis_rst=1 on the next cycle -> r1_rvalid stays 0, all BRAM outputs 0, conflict_cnt=0.
REQ-032 Force conflict_cnt to 16'hFFFF, then hold both valids 3 cycles -> conflict_cnt stays 16'hFFFF.
